// File: rtl/alarm_link_pkg.sv
// ============================================================================
// Module   : alarm_link_pkg
// Brief    : Shared definitions for the alarm status serial link.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alarm_link_pkg;

    localparam int MSG_W     = 4;

    localparam int IDX_ARMED = 0;
    localparam int IDX_ALARM = 1;
    localparam int IDX_S1    = 2;
    localparam int IDX_S2    = 3;

    // Minimum idle cycles the transmitter leaves between frames
    localparam int SB        = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/link_watchdog.sv
// ============================================================================
// Module   : link_watchdog
// Brief    : Saturating frame-gap counter that drives the link-good flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module link_watchdog #(
    parameter int TIMEOUT_CYC = 64,
    parameter int TO_W        = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_link_ok
);

    localparam logic [TO_W-1:0] c_timeout    = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] c_timeout_m1 = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] r_cnt;
    logic            r_link_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_link_ok <= 1'b0;
        end else if (i_clr) begin
            r_cnt     <= '0;
            r_link_ok <= 1'b1;
        end else if (r_cnt != c_timeout) begin
            r_cnt <= r_cnt + 1'b1;
            // Drop the flag in the same cycle the count lands on the limit
            if (r_cnt == c_timeout_m1) begin
                r_link_ok <= 1'b0;
            end
        end
    end

    assign o_link_ok = r_link_ok;

endmodule

`default_nettype wire

// File: rtl/status_serial_rx.sv
// ============================================================================
// Module   : status_serial_rx
// Brief    : Alarm status frame deserialiser with framing check and watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module status_serial_rx #(
    parameter int MSG_W       = alarm_link_pkg::MSG_W,
    parameter int TIMEOUT_CYC = 64,
    parameter int TO_W        = 7
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             STATUS_RECV,
    input  logic             STATUS_IN,
    output logic [MSG_W-1:0] MSG_OUT,
    output logic             MSG_VALID,
    output logic             MSG_CHANGED,
    output logic             ARMED,
    output logic             ALARM,
    output logic             SENSOR1,
    output logic             SENSOR2,
    output logic             LINK_OK,
    output logic             FRAME_ERR
);

    import alarm_link_pkg::*;

    localparam int                c_cnt_w    = (MSG_W > 1) ? $clog2(MSG_W) : 1;
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(MSG_W - 1);

    rx_state_t          r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [MSG_W-2:0]   r_shift, w_shift_nxt;
    logic [MSG_W-1:0]   w_frame;
    logic [MSG_W-1:0]   r_msg;
    logic               w_commit;
    logic               w_abort;
    logic               r_valid;
    logic               r_changed;
    logic               r_frame_err;

    // The final bit bypasses the shift register so the commit lands at t+5
    assign w_frame = {r_shift, STATUS_IN};

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_commit      = 1'b0;
        w_abort       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (STATUS_RECV) begin
                    w_state_nxt   = ST_SHIFT;
                    w_bit_cnt_nxt = '0;
                    w_shift_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                if (r_bit_cnt == c_last_bit) begin
                    w_commit      = 1'b1;
                    w_bit_cnt_nxt = '0;
                    w_shift_nxt   = '0;
                    w_state_nxt   = STATUS_RECV ? ST_SHIFT : ST_IDLE;
                end else if (STATUS_RECV) begin
                    w_abort       = 1'b1;
                    w_bit_cnt_nxt = '0;
                    w_shift_nxt   = '0;
                end else begin
                    w_shift_nxt   = w_frame[MSG_W-2:0];
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_msg       <= '0;
            r_valid     <= 1'b0;
            r_changed   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= w_commit;
            r_changed   <= w_commit && (w_frame != r_msg);
            r_frame_err <= w_abort;
            if (w_commit) begin
                r_msg <= w_frame;
            end
        end
    end

    link_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_link_watchdog (
        .clk       (CLK),
        .rst       (RST),
        .i_clr     (w_commit),
        .o_link_ok (LINK_OK)
    );

    assign MSG_OUT     = r_msg;
    assign MSG_VALID   = r_valid;
    assign MSG_CHANGED = r_changed;
    assign FRAME_ERR   = r_frame_err;
    assign ARMED       = r_msg[IDX_ARMED];
    assign ALARM       = r_msg[IDX_ALARM];
    assign SENSOR1     = r_msg[IDX_S1];
    assign SENSOR2     = r_msg[IDX_S2];

endmodule

`default_nettype wire

// File: tb/tb_status_serial_rx.sv
// ============================================================================
// Module   : tb_status_serial_rx
// Brief    : Scoreboard bench for the alarm status frame receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_status_serial_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       status_recv = 1'b0;
    logic       status_in = 1'b0;
    logic [3:0] msg_out;
    logic       msg_valid, msg_changed, armed, alarm, sensor1, sensor2;
    logic       link_ok, frame_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_start = 0;
    logic [3:0] model_msg = 4'd0;

    typedef struct {
        int         cyc;
        logic [3:0] msg;
        logic       chg;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];

    status_serial_rx dut (
        .CLK         (clk),
        .RST         (rst),
        .STATUS_RECV (status_recv),
        .STATUS_IN   (status_in),
        .MSG_OUT     (msg_out),
        .MSG_VALID   (msg_valid),
        .MSG_CHANGED (msg_changed),
        .ARMED       (armed),
        .ALARM       (alarm),
        .SENSOR1     (sensor1),
        .SENSOR2     (sensor2),
        .LINK_OK     (link_ok),
        .FRAME_ERR   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expected commits / framing errors as the DUT presents them
    always @(negedge clk) begin
        exp_t e;
        if (msg_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid cyc=%0d msg=%b", cyc, msg_out);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || msg_out !== e.msg || msg_changed !== e.chg || link_ok !== 1'b1 ||
                    {sensor2, sensor1, alarm, armed} !== e.msg) begin
                    bad++;
                    $display("FAIL commit got cyc=%0d msg=%b chg=%b link=%b flags=%b want cyc=%0d msg=%b chg=%b link=1",
                             cyc, msg_out, msg_changed, link_ok, {sensor2, sensor1, alarm, armed},
                             e.cyc, e.msg, e.chg);
                end
            end
        end else if (msg_changed) begin
            total++;
            bad++;
            $display("FAIL changed_without_valid cyc=%0d got=1 want=0", cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missed_valid got none want cyc=%0d msg=%b", e.cyc, e.msg);
        end
        if (frame_err) begin
            total++;
            if (err_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_frame_err cyc=%0d got=1 want=0", cyc);
            end else begin
                int ec;
                ec = err_q.pop_front();
                if (ec != cyc) begin
                    bad++;
                    $display("FAIL frame_err_cycle got=%0d want=%0d", cyc, ec);
                end
            end
        end
        if (err_q.size() > 0 && err_q[0] < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_frame_err got none want cyc=%0d", err_q.pop_front());
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            status_recv = 1'b0;
            status_in   = 1'b0;
        end
    endtask

    // Sends one frame; with end_strobe the next frame starts on the last-bit cycle
    task automatic frame(input logic [3:0] bits, input bit do_strobe, input bit end_strobe);
        if (do_strobe) begin
            tick();
            status_recv = 1'b1;
            status_in   = 1'b0;
            t_start     = cyc;
        end
        for (int i = 3; i >= 0; i--) begin
            tick();
            status_recv = (i == 0) && end_strobe;
            status_in   = bits[i];
        end
        exp_q.push_back('{cyc: t_start + 5, msg: bits, chg: (bits != model_msg)});
        model_msg = bits;
        if (end_strobe) t_start = cyc;
    endtask

    task automatic chk_all_zero(input string name);
        @(negedge clk);
        chk(name, {msg_out, msg_valid, msg_changed, armed, alarm, sensor1, sensor2, link_ok, frame_err}, 32'd0);
    endtask

    initial begin
        int c;
        int s;
        repeat (3) tick();
        chk_all_zero("reset_state");
        rst = 1'b0;
        while (cyc < 9) idle(1);

        // First frame: strobe at cycle 10, commit visible at cycle 15
        frame(4'b1011, 1'b1, 1'b0);
        idle(1);
        @(negedge clk);
        chk("first_cycle", cyc, 15);
        chk("first_flags", {armed, alarm, sensor1, sensor2, link_ok}, 5'b11011);

        // Identical frame: valid but no change strobe
        idle(3);
        frame(4'b1011, 1'b1, 1'b0);
        idle(1);
        @(negedge clk);
        chk("repeat_msg", msg_out, 4'b1011);

        // Abort after two bits, restarting on the second strobe
        idle(3);
        tick();
        status_recv = 1'b1;
        s = cyc;
        err_q.push_back(s + 4);
        tick();
        status_recv = 1'b0;
        status_in   = 1'b1;
        tick();
        status_in   = 1'b0;
        frame(4'b0001, 1'b1, 1'b0);
        chk("abort_restart_cycle", t_start, s + 3);
        idle(1);
        @(negedge clk);
        chk("abort_msg", msg_out, 4'b0001);

        // Back-to-back frames with the second strobe on the last-bit cycle
        idle(3);
        frame(4'b0011, 1'b1, 1'b1);
        frame(4'b0100, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        chk("b2b_msg", msg_out, 4'b0100);

        // Watchdog: link drops exactly TIMEOUT_CYC cycles after the commit cycle
        idle(3);
        frame(4'b1000, 1'b1, 1'b0);
        c = t_start + 5;
        while (cyc < c + 63) idle(1);
        @(negedge clk);
        chk("wd_before_timeout", link_ok, 1'b1);
        idle(1);
        @(negedge clk);
        chk("wd_at_timeout", link_ok, 1'b0);
        chk("wd_msg_retained", msg_out, 4'b1000);
        idle(10);
        @(negedge clk);
        chk("wd_stays_low", link_ok, 1'b0);
        frame(4'b1000, 1'b1, 1'b0);
        idle(1);
        @(negedge clk);
        chk("wd_restored", link_ok, 1'b1);

        // Reset asserted on the third payload bit
        idle(3);
        tick();
        status_recv = 1'b1;
        status_in   = 1'b0;
        tick();
        status_recv = 1'b0;
        status_in   = 1'b1;
        tick();
        status_in   = 1'b0;
        tick();
        status_in   = 1'b1;
        rst         = 1'b1;
        tick();
        rst         = 1'b0;
        status_in   = 1'b0;
        model_msg   = 4'd0;
        chk_all_zero("mid_frame_reset");
        idle(3);
        @(negedge clk);
        chk("post_reset_quiet", {msg_valid, frame_err, link_ok}, 3'b000);
        frame(4'b0110, 1'b1, 1'b0);
        idle(1);
        @(negedge clk);
        chk("post_reset_frame", {msg_out, armed, alarm, sensor1, sensor2}, 8'b0110_0110);

        idle(8);
        @(negedge clk);
        chk("pending_commits", exp_q.size(), 0);
        chk("pending_frame_errs", err_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
